// File: rtl/apb_pkg.sv
// Shared types for the queued APB4 master: FSM state encoding and derived
// field widths of the command/response words.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } state_t;

  typedef enum logic [1:0] {W_STRB, W_CMD, W_RESP} wsel_e;

  // Command word is {pwrite, pstrb, pwdata, paddr}; response is {pslverr, prdata}.
  function automatic int apb_width(input int dw, input int aw, input wsel_e sel);
    case (sel)
      W_STRB:  return dw / 8;
      W_CMD:   return 1 + dw / 8 + dw + aw;
      default: return 1 + dw;
    endcase
  endfunction

endpackage

// File: rtl/apb_master_q_if.sv
// Command/response queues plus APB bus of apb_master_q, bundled as one interface.
interface apb_master_q_if #(
  parameter int DW = 32,
  parameter int AW = 8
);
  import apb_pkg::*;

  localparam int SW = apb_width(DW, AW, W_STRB);
  localparam int CW = apb_width(DW, AW, W_CMD);
  localparam int RW = apb_width(DW, AW, W_RESP);

  logic [CW-1:0] i_cmd;
  logic          i_cmd_valid;
  logic          o_cmd_ready;
  logic [RW-1:0] o_resp;
  logic          o_resp_valid;
  logic          i_resp_ready;
  logic [AW-1:0] o_paddr;
  logic          o_pwrite;
  logic          o_psel;
  logic          o_penable;
  logic [DW-1:0] o_pwdata;
  logic [SW-1:0] o_pstrb;
  logic [DW-1:0] i_prdata;
  logic          i_pslverr;
  logic          i_pready;
  logic          o_tout;

  modport master (
    input  i_cmd, i_cmd_valid, i_resp_ready, i_prdata, i_pslverr, i_pready,
    output o_cmd_ready, o_resp, o_resp_valid, o_paddr, o_pwrite, o_psel,
           o_penable, o_pwdata, o_pstrb, o_tout
  );

  modport slave (
    output i_cmd, i_cmd_valid, i_resp_ready, i_prdata, i_pslverr, i_pready,
    input  o_cmd_ready, o_resp, o_resp_valid, o_paddr, o_pwrite, o_psel,
           o_penable, o_pwdata, o_pstrb, o_tout
  );

endinterface

// File: rtl/apb_sfifo.sv
// Synchronous FIFO with registered count and registered ready/valid flags.
module apb_sfifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_push,
  output logic                   o_ready,
  output logic [WIDTH-1:0]       o_data,
  input  logic                   i_pop,
  output logic                   o_valid,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr, r_rptr;
  logic [PW:0]      r_cnt, w_cnt_nxt;
  logic             r_rdy, r_vld;
  logic             w_push, w_pop;

  assign w_push = i_push & r_rdy;
  assign w_pop  = i_pop & r_vld;

  always_comb begin
    w_cnt_nxt = r_cnt;
    case ({w_push, w_pop})
      2'b10:   w_cnt_nxt = r_cnt + 1'b1;
      2'b01:   w_cnt_nxt = r_cnt - 1'b1;
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  // Flags come from the next count so they are plain flops at the outputs;
  // ready is held low through reset and rises one cycle after release.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_rdy  <= 1'b0;
      r_vld  <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_cnt <= w_cnt_nxt;
      r_rdy <= (w_cnt_nxt != FULL);
      r_vld <= (w_cnt_nxt != '0);
    end
  end

  assign o_ready = r_rdy;
  assign o_valid = r_vld;
  assign o_count = r_cnt;
  assign o_data  = r_vld ? r_mem[r_rptr] : '0;

endmodule

// File: rtl/apb_master_q.sv
// Queued APB4 master: command FIFO -> IDLE/SETUP/ACCESS FSM -> response FIFO.
// Optional PREADY timeout compiled in with APB_MASTER_TIMEOUT_EN.
module apb_master_q
  import apb_pkg::*;
#(
  parameter int DW       = 32,
  parameter int AW       = 8,
  parameter int DEPTH    = 4,
  parameter int TOUT_CYC = 256
) (
  input  logic              pclk,
  input  logic              preset,
  apb_master_q_if.master    bus
);
  localparam int SW   = apb_width(DW, AW, W_STRB);
  localparam int CW   = apb_width(DW, AW, W_CMD);
  localparam int RW   = apb_width(DW, AW, W_RESP);
  localparam int CNTW = $clog2(DEPTH) + 1;
  localparam logic [CNTW-1:0] AFULL = CNTW'(DEPTH - 1);

  state_t          r_state, w_nxt;
  logic            r_psel, r_penable, r_pwrite;
  logic [AW-1:0]   r_paddr;
  logic [DW-1:0]   r_pwdata;
  logic [SW-1:0]   r_pstrb;

  logic [CW-1:0]   w_cmd_head;
  logic            w_cmd_vld;
  logic [CNTW-1:0] w_unused_cmd_cnt;
  logic [CNTW-1:0] w_resp_cnt;
  logic            w_unused_resp_rdy;
  logic [RW-1:0]   w_resp_data;
  logic            w_start, w_done, w_abort;
  logic            w_free1, w_free2;

  apb_sfifo #(.WIDTH(CW), .DEPTH(DEPTH)) u_cmd_fifo (
    .clk     (pclk),
    .rst     (preset),
    .i_data  (bus.i_cmd),
    .i_push  (bus.i_cmd_valid),
    .o_ready (bus.o_cmd_ready),
    .o_data  (w_cmd_head),
    .i_pop   (w_start),
    .o_valid (w_cmd_vld),
    .o_count (w_unused_cmd_cnt)
  );

  apb_sfifo #(.WIDTH(RW), .DEPTH(DEPTH)) u_resp_fifo (
    .clk     (pclk),
    .rst     (preset),
    .i_data  (w_resp_data),
    .i_push  (w_done | w_abort),
    .o_ready (w_unused_resp_rdy),
    .o_data  (bus.o_resp),
    .i_pop   (bus.i_resp_ready),
    .o_valid (bus.o_resp_valid),
    .o_count (w_resp_cnt)
  );

  // Registered count only: a consumer pop in the same cycle is not credited.
  assign w_free1 = (w_resp_cnt <= AFULL);
  assign w_free2 = (w_resp_cnt < AFULL);

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TOUT_CYC) + 1;
  logic [TW-1:0] r_tcnt;
  logic          w_tout_hit;

  assign w_tout_hit = (r_state == ACCESS) && !bus.i_pready &&
                      (r_tcnt == TW'(TOUT_CYC - 1));

  // Cleared while in SETUP so the first ACCESS cycle sees zero.
  always_ff @(posedge pclk) begin
    if (preset || r_state == SETUP) r_tcnt <= '0;
    else if (r_state == ACCESS && !bus.i_pready && !w_tout_hit) r_tcnt <= r_tcnt + 1'b1;
  end
`else
  localparam int unused_tout_cyc = TOUT_CYC;
`endif

  always_comb begin
    w_nxt   = r_state;
    w_start = 1'b0;
    w_done  = 1'b0;
    w_abort = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_cmd_vld && w_free1) begin
          w_nxt   = SETUP;
          w_start = 1'b1;
        end
      end
      SETUP: w_nxt = ACCESS;
      ACCESS: begin
        if (bus.i_pready) begin
          w_done = 1'b1;
          // Back-to-back needs room for this response and the next one.
          if (w_cmd_vld && w_free2) begin
            w_nxt   = SETUP;
            w_start = 1'b1;
          end else begin
            w_nxt = IDLE;
          end
        end
`ifdef APB_MASTER_TIMEOUT_EN
        else if (w_tout_hit) begin
          w_abort = 1'b1;
          w_nxt   = IDLE;
        end
`endif
      end
      default: w_nxt = IDLE;
    endcase
  end

  assign w_resp_data = w_abort ? {1'b1, {DW{1'b0}}} : {bus.i_pslverr, bus.i_prdata};

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state   <= IDLE;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_pstrb   <= '0;
    end else begin
      r_state   <= w_nxt;
      r_psel    <= (w_nxt != IDLE);
      r_penable <= (w_nxt == ACCESS);
      // Address/data phase fields hold across IDLE until the next start.
      if (w_start) begin
        r_pwrite <= w_cmd_head[CW-1];
        r_pstrb  <= w_cmd_head[CW-1] ? w_cmd_head[AW+DW +: SW] : '0;
        r_pwdata <= w_cmd_head[AW +: DW];
        r_paddr  <= w_cmd_head[AW-1:0];
      end
    end
  end

  assign bus.o_psel    = r_psel;
  assign bus.o_penable = r_penable;
  assign bus.o_pwrite  = r_pwrite;
  assign bus.o_paddr   = r_paddr;
  assign bus.o_pwdata  = r_pwdata;
  assign bus.o_pstrb   = r_pstrb;
  assign bus.o_tout    = w_abort & ~preset;

endmodule

// File: tb/tb_apb_master_q.sv
// Directed self-checking bench for apb_master_q (DW=32, AW=8, DEPTH=4, TOUT_CYC=8).
module tb_apb_master_q;
  localparam int CW = 45;
  localparam int RW = 33;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic auto_rd = 1'b0;
  logic [31:0] prdata_drv = '0;
  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  apb_master_q_if #(.DW(32), .AW(8)) bus ();

  apb_master_q #(.DW(32), .AW(8), .DEPTH(4), .TOUT_CYC(8)) dut (
    .pclk   (clk),
    .preset (rst),
    .bus    (bus)
  );

  // Read data echoes the address so response order is visible.
  assign bus.i_prdata = auto_rd ? {24'hC0FFEE, bus.o_paddr} : prdata_drv;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CW-1:0] mk(input logic w, input logic [3:0] s,
                                       input logic [31:0] d, input logic [7:0] a);
    return {w, s, d, a};
  endfunction

  task automatic push_cmd(input logic [CW-1:0] c);
    int n;
    n = 0;
    bus.i_cmd = c;
    bus.i_cmd_valid = 1'b1;
    while (!bus.o_cmd_ready && n < 50) begin tick(); n++; end
    if (!bus.o_cmd_ready) begin
      ncmp++; nfail++;
      $display("FAIL push_bound: cmd_ready=%b required 1 within 50 cycles", bus.o_cmd_ready);
    end
    tick();
    bus.i_cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.i_cmd = '0; bus.i_cmd_valid = 1'b0; bus.i_resp_ready = 1'b0;
    bus.i_pslverr = 1'b0; bus.i_pready = 1'b1;
    rst = 1'b1;
    repeat (3) tick();
    ncmp++; if (bus.o_psel !== 1'b0) begin nfail++; $display("FAIL rst_psel: got %b want 0", bus.o_psel); end
    ncmp++; if (bus.o_penable !== 1'b0) begin nfail++; $display("FAIL rst_penable: got %b want 0", bus.o_penable); end
    ncmp++; if (bus.o_cmd_ready !== 1'b0) begin nfail++; $display("FAIL rst_cmd_ready: got %b want 0", bus.o_cmd_ready); end
    ncmp++; if (bus.o_resp_valid !== 1'b0) begin nfail++; $display("FAIL rst_resp_valid: got %b want 0", bus.o_resp_valid); end
    ncmp++; if (bus.o_tout !== 1'b0) begin nfail++; $display("FAIL rst_tout: got %b want 0", bus.o_tout); end
    rst = 1'b0;
    tick();
    ncmp++; if (bus.o_cmd_ready !== 1'b1) begin nfail++; $display("FAIL rst_release_ready: got %b want 1", bus.o_cmd_ready); end
  endtask

  task automatic test_single_write();
    bus.i_pready = 1'b1; bus.i_resp_ready = 1'b0;
    bus.i_cmd = mk(1'b1, 4'hF, 32'hDEADBEEF, 8'h10);
    bus.i_cmd_valid = 1'b1;
    ncmp++; if (bus.o_cmd_ready !== 1'b1) begin nfail++; $display("FAIL wr_ready_T: got %b want 1", bus.o_cmd_ready); end
    tick(); bus.i_cmd_valid = 1'b0;
    ncmp++; if (bus.o_psel !== 1'b0) begin nfail++; $display("FAIL wr_psel_T1: got %b want 0", bus.o_psel); end
    tick();
    ncmp++; if ({bus.o_psel, bus.o_penable} !== 2'b10) begin nfail++; $display("FAIL wr_setup_T2: psel/penable %b want 10", {bus.o_psel, bus.o_penable}); end
    ncmp++; if ({bus.o_pwrite, bus.o_pstrb, bus.o_pwdata, bus.o_paddr} !== mk(1'b1, 4'hF, 32'hDEADBEEF, 8'h10)) begin
      nfail++; $display("FAIL wr_fields: got %h want %h", {bus.o_pwrite, bus.o_pstrb, bus.o_pwdata, bus.o_paddr}, mk(1'b1, 4'hF, 32'hDEADBEEF, 8'h10)); end
    tick();
    ncmp++; if ({bus.o_psel, bus.o_penable} !== 2'b11) begin nfail++; $display("FAIL wr_access_T3: psel/penable %b want 11", {bus.o_psel, bus.o_penable}); end
    ncmp++; if (bus.o_resp_valid !== 1'b0) begin nfail++; $display("FAIL wr_resp_T3: got %b want 0", bus.o_resp_valid); end
    tick();
    ncmp++; if (bus.o_resp_valid !== 1'b1) begin nfail++; $display("FAIL wr_resp_T4: got %b want 1", bus.o_resp_valid); end
    ncmp++; if (bus.o_resp[32] !== 1'b0) begin nfail++; $display("FAIL wr_slverr: got %b want 0", bus.o_resp[32]); end
    ncmp++; if ({bus.o_psel, bus.o_penable} !== 2'b00) begin nfail++; $display("FAIL wr_idle_T4: psel/penable %b want 00", {bus.o_psel, bus.o_penable}); end
    ncmp++; if (bus.o_paddr !== 8'h10) begin nfail++; $display("FAIL wr_paddr_hold: got %h want 10", bus.o_paddr); end
    bus.i_resp_ready = 1'b1; tick(); bus.i_resp_ready = 1'b0;
    ncmp++; if (bus.o_resp_valid !== 1'b0) begin nfail++; $display("FAIL wr_pop: resp_valid %b want 0", bus.o_resp_valid); end
  endtask

  task automatic test_read_wait();
    int hi;
    hi = 0;
    push_cmd(mk(1'b0, 4'hF, 32'hAAAA5555, 8'h24));
    tick();
    ncmp++; if ({bus.o_psel, bus.o_pwrite, bus.o_pstrb, bus.o_paddr} !== {1'b1, 1'b0, 4'h0, 8'h24}) begin
      nfail++; $display("FAIL rd_setup: psel/pwrite/pstrb/paddr %h want %h", {bus.o_psel, bus.o_pwrite, bus.o_pstrb, bus.o_paddr}, {1'b1, 1'b0, 4'h0, 8'h24}); end
    bus.i_pready = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (bus.o_penable) hi++;
      if (i == 3) begin bus.i_pready = 1'b1; prdata_drv = 32'h12345678; bus.i_pslverr = 1'b1; end
      tick();
    end
    bus.i_pslverr = 1'b0; prdata_drv = '0;
    ncmp++; if (hi !== 4) begin nfail++; $display("FAIL rd_penable_cycles: got %0d want 4", hi); end
    ncmp++; if (bus.o_penable !== 1'b0) begin nfail++; $display("FAIL rd_penable_drop: got %b want 0", bus.o_penable); end
    ncmp++; if (bus.o_resp_valid !== 1'b1) begin nfail++; $display("FAIL rd_resp_valid: got %b want 1", bus.o_resp_valid); end
    ncmp++; if (bus.o_resp !== {1'b1, 32'h12345678}) begin nfail++; $display("FAIL rd_resp: got %h want %h", bus.o_resp, {1'b1, 32'h12345678}); end
    bus.i_resp_ready = 1'b1; tick(); bus.i_resp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int gaps, comp, got;
    logic [7:0] a;
    gaps = 0; comp = 0; got = 0;
    auto_rd = 1'b1; bus.i_pready = 1'b0; bus.i_resp_ready = 1'b1;
    for (int k = 0; k < 5; k++) push_cmd(mk(1'b0, 4'h0, 32'h0, 8'h40 + 8'(k)));
    ncmp++; if (bus.o_cmd_ready !== 1'b0) begin nfail++; $display("FAIL b2b_full: cmd_ready %b want 0", bus.o_cmd_ready); end
    ncmp++; if (bus.o_penable !== 1'b1) begin nfail++; $display("FAIL b2b_stall: penable %b want 1", bus.o_penable); end
    bus.i_pready = 1'b1;
    for (int c = 0; c < 60 && got < 5; c++) begin
      if (comp < 5 && !bus.o_psel) gaps++;
      if (bus.o_penable) comp++;
      if (bus.o_resp_valid) begin
        a = 8'h40 + 8'(got);
        ncmp++; if (bus.o_resp !== {1'b0, 24'hC0FFEE, a}) begin nfail++; $display("FAIL b2b_resp%0d: got %h want %h", got, bus.o_resp, {1'b0, 24'hC0FFEE, a}); end
        got++;
      end
      tick();
    end
    ncmp++; if (got !== 5) begin nfail++; $display("FAIL b2b_count: got %0d responses want 5", got); end
    ncmp++; if (gaps !== 0) begin nfail++; $display("FAIL b2b_gap: got %0d idle cycles want 0", gaps); end
    ncmp++; if (bus.o_cmd_ready !== 1'b1) begin nfail++; $display("FAIL b2b_ready_back: got %b want 1", bus.o_cmd_ready); end
    bus.i_resp_ready = 1'b0;
  endtask

  task automatic test_resp_backpressure();
    int xf, xf2, got;
    logic [7:0] a;
    xf = 0; xf2 = 0; got = 0;
    auto_rd = 1'b1; bus.i_pready = 1'b1; bus.i_resp_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 6; k++) push_cmd(mk(1'b0, 4'h0, 32'h0, 8'h50 + 8'(k)));
      end
      begin
        for (int c = 0; c < 40; c++) begin
          if (bus.o_penable) xf++;
          tick();
        end
      end
    join
    ncmp++; if (xf !== 4) begin nfail++; $display("FAIL bp_xfers: got %0d want 4", xf); end
    ncmp++; if (bus.o_psel !== 1'b0) begin nfail++; $display("FAIL bp_psel: got %b want 0", bus.o_psel); end
    ncmp++; if (bus.o_cmd_ready !== 1'b1) begin nfail++; $display("FAIL bp_cmd_ready: got %b want 1", bus.o_cmd_ready); end
    bus.i_resp_ready = 1'b1;
    for (int c = 0; c < 60 && got < 6; c++) begin
      if (bus.o_penable) xf2++;
      if (bus.o_resp_valid) begin
        a = 8'h50 + 8'(got);
        ncmp++; if (bus.o_resp !== {1'b0, 24'hC0FFEE, a}) begin nfail++; $display("FAIL bp_resp%0d: got %h want %h", got, bus.o_resp, {1'b0, 24'hC0FFEE, a}); end
        got++;
      end
      tick();
    end
    ncmp++; if (got !== 6) begin nfail++; $display("FAIL bp_count: got %0d responses want 6", got); end
    ncmp++; if (xf2 !== 2) begin nfail++; $display("FAIL bp_drain_xfers: got %0d want 2", xf2); end
    bus.i_resp_ready = 1'b0;
  endtask

  task automatic test_timeout();
    int pulses, at, hi;
    pulses = 0; at = 0; hi = 0;
    auto_rd = 1'b1; bus.i_pready = 1'b0; bus.i_resp_ready = 1'b0;
    push_cmd(mk(1'b0, 4'h0, 32'h0, 8'h60));
    tick(); tick();
`ifdef APB_MASTER_TIMEOUT_EN
    for (int i = 1; i <= 8; i++) begin
      if (bus.o_tout) begin pulses++; at = i; end
      tick();
    end
    ncmp++; if (pulses !== 1 || at !== 8) begin nfail++; $display("FAIL to_pulse: pulses %0d at %0d want 1 at 8", pulses, at); end
    ncmp++; if ({bus.o_psel, bus.o_tout} !== 2'b00) begin nfail++; $display("FAIL to_idle: psel/tout %b want 00", {bus.o_psel, bus.o_tout}); end
    ncmp++; if ({bus.o_resp_valid, bus.o_resp} !== {1'b1, 1'b1, 32'h0}) begin nfail++; $display("FAIL to_resp: got %h want %h", {bus.o_resp_valid, bus.o_resp}, {1'b1, 1'b1, 32'h0}); end
    bus.i_resp_ready = 1'b1; tick(); bus.i_resp_ready = 1'b0;
    pulses = 0;
    push_cmd(mk(1'b0, 4'h0, 32'h0, 8'h61));
    tick(); tick();
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) bus.i_pready = 1'b1;
      if (bus.o_tout) pulses++;
      tick();
    end
    ncmp++; if (pulses !== 0) begin nfail++; $display("FAIL to_race_pulse: got %0d want 0", pulses); end
    ncmp++; if ({bus.o_resp_valid, bus.o_resp} !== {1'b1, 1'b0, 32'hC0FFEE61}) begin nfail++; $display("FAIL to_race_resp: got %h want %h", {bus.o_resp_valid, bus.o_resp}, {1'b1, 1'b0, 32'hC0FFEE61}); end
`else
    for (int i = 1; i <= 20; i++) begin
      if (bus.o_tout) pulses++;
      if (bus.o_penable) hi++;
      tick();
    end
    ncmp++; if (pulses !== 0 || hi !== 20) begin nfail++; $display("FAIL nt_wait: tout %0d penable %0d want 0/20", pulses, hi); end
    bus.i_pready = 1'b1; tick();
    ncmp++; if ({bus.o_resp_valid, bus.o_resp} !== {1'b1, 1'b0, 32'hC0FFEE60}) begin nfail++; $display("FAIL nt_resp: got %h want %h", {bus.o_resp_valid, bus.o_resp}, {1'b1, 1'b0, 32'hC0FFEE60}); end
`endif
    bus.i_pready = 1'b1;
    bus.i_resp_ready = 1'b1; tick(); bus.i_resp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    auto_rd = 1'b1; bus.i_pready = 1'b0; bus.i_resp_ready = 1'b1;
    for (int k = 0; k < 3; k++) push_cmd(mk(1'b0, 4'h0, 32'h0, 8'h70 + 8'(k)));
    ncmp++; if (bus.o_penable !== 1'b1) begin nfail++; $display("FAIL rm_access: penable %b want 1", bus.o_penable); end
    rst = 1'b1; tick();
    ncmp++; if ({bus.o_psel, bus.o_penable, bus.o_resp_valid, bus.o_cmd_ready} !== 4'b0000) begin
      nfail++; $display("FAIL rm_reset: psel/penable/resp_valid/cmd_ready %b want 0000", {bus.o_psel, bus.o_penable, bus.o_resp_valid, bus.o_cmd_ready}); end
    rst = 1'b0; bus.i_pready = 1'b1; tick();
    ncmp++; if (bus.o_cmd_ready !== 1'b1) begin nfail++; $display("FAIL rm_ready: got %b want 1", bus.o_cmd_ready); end
    tick(); tick();
    ncmp++; if ({bus.o_psel, bus.o_resp_valid} !== 2'b00) begin nfail++; $display("FAIL rm_flushed: psel/resp_valid %b want 00", {bus.o_psel, bus.o_resp_valid}); end
    bus.i_resp_ready = 1'b0;
    push_cmd(mk(1'b1, 4'h3, 32'hCAFEF00D, 8'h77));
    n = 0;
    while (!bus.o_resp_valid && n < 12) begin tick(); n++; end
    ncmp++; if ({bus.o_resp_valid, bus.o_resp} !== {1'b1, 1'b0, 32'hC0FFEE77}) begin nfail++; $display("FAIL rm_after: got %h want %h", {bus.o_resp_valid, bus.o_resp}, {1'b1, 1'b0, 32'hC0FFEE77}); end
    ncmp++; if (bus.o_pstrb !== 4'h3) begin nfail++; $display("FAIL rm_pstrb: got %h want 3", bus.o_pstrb); end
    bus.i_resp_ready = 1'b1; tick(); bus.i_resp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_wait();
    test_back_to_back();
    test_resp_backpressure();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
